// File: rtl/fma_vec_pipe.sv
// fma_vec_pipe -- LANES-wide integer fused multiply-add with a fixed-depth,
// stallable result pipeline.
//
// Each lane computes (modulo 2^W) one of a*b+c, a*b-c, c-a*b or a*b, chosen
// by a mode shared across the bundle. The result is formed combinationally
// into stage 0 and then travels DELAY stages before reaching the outputs.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset (clears every stage and the count)
//   clken      global clock enable; low freezes all state
//   in_valid   operand bundle present
//   in_ready   bundle accepted this cycle (combinational: advance)
//   in_a/b/c   packed lane operands, lane i at [i*W +: W]
//   in_mode    00 a*b+c, 01 a*b-c, 10 c-a*b, 11 a*b
//   in_tag     sideband tag returned with the result
//   out_valid  result bundle present (last stage valid bit)
//   out_ready  downstream consumes the result this cycle
//   out_data   packed lane results
//   out_tag    tag of the bundle on out_data
//   inflight   number of valid bundles held in the pipeline
module fma_vec_pipe #(
   parameter int W     = 32,
   parameter int LANES = 4,
   parameter int DELAY = 21,
   parameter int TAG_W = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clken,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [LANES*W-1:0]           in_a,
   input  logic [LANES*W-1:0]           in_b,
   input  logic [LANES*W-1:0]           in_c,
   input  logic [1:0]                   in_mode,
   input  logic [TAG_W-1:0]             in_tag,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [LANES*W-1:0]           out_data,
   output logic [TAG_W-1:0]             out_tag,
   output logic [$clog2(DELAY+1)-1:0]   inflight
);

   localparam int CNT_W = $clog2(DELAY + 1);

   typedef enum logic [1:0] {
      MODE_MAC  = 2'b00,
      MODE_MSC  = 2'b01,
      MODE_NMAC = 2'b10,
      MODE_MUL  = 2'b11
   } mode_e;

   logic [DELAY-1:0]   valid_q;
   logic [LANES*W-1:0] data_q [DELAY];
   logic [TAG_W-1:0]   tag_q  [DELAY];
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [LANES*W-1:0] result_d;
   logic [W-1:0]       a_l, b_l, c_l, prod_l;
   mode_e              mode_s;
   logic               advance, accept, consume;

   assign mode_s = mode_e'(in_mode);

   // A bubble in the last stage never blocks a shift.
   assign advance  = clken & (~valid_q[DELAY-1] | out_ready);
   assign in_ready = advance;
   assign accept   = in_valid & advance;
   assign consume  = valid_q[DELAY-1] & out_ready & clken;

   assign out_valid = valid_q[DELAY-1];
   assign out_data  = data_q[DELAY-1];
   assign out_tag   = tag_q[DELAY-1];
   assign inflight  = cnt_q;

   // Per-lane arithmetic; all sums and products wrap at W bits.
   always_comb begin
      result_d = '0;
      a_l      = '0;
      b_l      = '0;
      c_l      = '0;
      prod_l   = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         a_l    = in_a[l*W +: W];
         b_l    = in_b[l*W +: W];
         c_l    = in_c[l*W +: W];
         prod_l = a_l * b_l;
         case (mode_s)
            MODE_MAC:  result_d[l*W +: W] = prod_l + c_l;
            MODE_MSC:  result_d[l*W +: W] = prod_l - c_l;
            MODE_NMAC: result_d[l*W +: W] = c_l - prod_l;
            MODE_MUL:  result_d[l*W +: W] = prod_l;
         endcase
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (accept && !consume)
         cnt_d = cnt_q + CNT_W'(1);
      else if (!accept && consume)
         cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         cnt_q   <= '0;
         for (int unsigned i = 0; i < DELAY; i++) begin
            data_q[i] <= '0;
            tag_q[i]  <= '0;
         end
      end else begin
         if (advance) begin
            valid_q[0] <= in_valid;
            data_q[0]  <= result_d;
            tag_q[0]   <= in_tag;
            for (int unsigned i = 1; i < DELAY; i++) begin
               valid_q[i] <= valid_q[i-1];
               data_q[i]  <= data_q[i-1];
               tag_q[i]   <= tag_q[i-1];
            end
         end
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_fma_vec_pipe.sv
// Bench for fma_vec_pipe: a queue of outstanding bundles, each with the number
// of advancing edges it has seen, stands in for the pipeline. Expected results
// come from plain modulo-2^32 arithmetic.
module tb_fma_vec_pipe;

   localparam int W     = 32;
   localparam int LANES = 4;
   localparam int DELAY = 21;
   localparam int TAG_W = 4;
   localparam int BW    = W * LANES;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             clken = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [BW-1:0]    in_a = '0, in_b = '0, in_c = '0;
   logic [1:0]       in_mode = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [BW-1:0]    out_data;
   logic [TAG_W-1:0] out_tag;
   logic [4:0]       inflight;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [BW-1:0]    data;
      logic [TAG_W-1:0] tag;
      int               age;
   } item_t;
   item_t q[$];

   always #5 clk = ~clk;

   fma_vec_pipe #(.W(W), .LANES(LANES), .DELAY(DELAY), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .clken(clken),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_c(in_c),
      .in_mode(in_mode), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag),
      .inflight(inflight)
   );

   function automatic logic [W-1:0] ref_lane(logic [W-1:0] a, logic [W-1:0] b,
                                             logic [W-1:0] c, logic [1:0] m);
      logic [W-1:0] p;
      p = a * b;
      case (m)
         2'd0:    return p + c;
         2'd1:    return p - c;
         2'd2:    return c - p;
         default: return p;
      endcase
   endfunction

   function automatic logic [BW-1:0] ref_bundle(logic [BW-1:0] a, logic [BW-1:0] b,
                                                logic [BW-1:0] c, logic [1:0] m);
      logic [BW-1:0] r;
      r = '0;
      for (int l = 0; l < LANES; l++)
         r[l*W +: W] = ref_lane(a[l*W +: W], b[l*W +: W], c[l*W +: W], m);
      return r;
   endfunction

   function automatic bit m_out_valid();
      return (q.size() > 0) && (q[0].age == DELAY - 1);
   endfunction

   function automatic bit m_ready();
      return clken && (!m_out_valid() || out_ready);
   endfunction

   task automatic randomize_inputs();
      for (int l = 0; l < LANES; l++) begin
         in_a[l*W +: W] = $urandom();
         in_b[l*W +: W] = $urandom();
         in_c[l*W +: W] = $urandom();
      end
      in_mode = 2'($urandom_range(3));
   endtask

   // One clock edge: updates the queue model from the inputs present now.
   task automatic tick(output bit acc);
      bit    adv, con;
      item_t it;
      adv     = clken && (!m_out_valid() || out_ready);
      con     = m_out_valid() && out_ready && clken;
      acc     = in_valid && adv && !rst;
      it.data = ref_bundle(in_a, in_b, in_c, in_mode);
      it.tag  = in_tag;
      it.age  = 0;
      @(posedge clk);
      if (rst) begin
         q.delete();
      end else if (adv) begin
         foreach (q[i]) q[i].age++;
         if (con) void'(q.pop_front());
         if (acc) q.push_back(it);
      end
      #1;
   endtask

   task automatic test_reset();
      bit acc;
      rst = 1'b1; clken = 1'b0; in_valid = 1'b1;
      tick(acc);
      tick(acc);
      rst = 1'b0; clken = 1'b1; in_valid = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b want 0", out_valid); end
      n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL rst_data: got %h want 0", out_data); end
      n_checks++; if (out_tag !== '0) begin n_fail++; $display("FAIL rst_tag: got %h want 0", out_tag); end
      n_checks++; if (inflight !== 5'd0) begin n_fail++; $display("FAIL rst_inflight: got %0d want 0", inflight); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b want 1", in_ready); end
      clken = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL clken0_ready: got %0b want 0", in_ready); end
      clken = 1'b1;
   endtask

   task automatic test_modes();
      bit            acc;
      logic [BW-1:0] exp_v [4];
      exp_v[0] = {LANES{32'd17}};
      exp_v[1] = {LANES{32'd13}};
      exp_v[2] = {LANES{32'hFFFF_FFF3}};
      exp_v[3] = {LANES{32'd15}};
      out_ready = 1'b1;
      in_a = {LANES{32'd3}}; in_b = {LANES{32'd5}}; in_c = {LANES{32'd2}};
      in_valid = 1'b1;
      for (int m = 0; m < 4; m++) begin
         in_mode = 2'(m); in_tag = 4'(m);
         tick(acc);
      end
      in_valid = 1'b0;
      for (int t = 4; t <= 24; t++) begin
         tick(acc);
         if (t == 19 || t == 24) begin
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL modes_early_late t=%0d: got valid %0b want 0", t, out_valid); end
         end else if (t >= 20 && t <= 23) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL modes_valid t=%0d: got %0b want 1", t, out_valid); end
            n_checks++; if (out_data !== exp_v[t-20]) begin n_fail++; $display("FAIL modes_data t=%0d: got %h want %h", t, out_data, exp_v[t-20]); end
            n_checks++; if (out_tag !== 4'(t-20)) begin n_fail++; $display("FAIL modes_tag t=%0d: got %0d want %0d", t, out_tag, t-20); end
         end
      end
   endtask

   task automatic test_wrap();
      bit acc;
      out_ready = 1'b1; in_valid = 1'b1;
      in_a = {LANES{32'h8000_0000}}; in_b = {LANES{32'd2}}; in_c = {LANES{32'd1}};
      in_mode = 2'b00; in_tag = 4'd9;
      tick(acc);
      in_a = {LANES{32'hFFFF_FFFF}}; in_b = {LANES{32'hFFFF_FFFF}}; in_c = '0;
      in_mode = 2'b11; in_tag = 4'd10;
      tick(acc);
      in_valid = 1'b0;
      for (int t = 2; t <= 22; t++) begin
         tick(acc);
         if (t == 20 || t == 21) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid t=%0d: got %0b want 1", t, out_valid); end
            n_checks++; if (out_data !== {LANES{32'd1}}) begin n_fail++; $display("FAIL wrap_data t=%0d: got %h want all-lanes 1", t, out_data); end
         end else if (t == 22) begin
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_after: got valid %0b want 0", out_valid); end
         end
      end
   endtask

   task automatic test_back_to_back();
      bit acc;
      int sent = 0, got = 0, cyc = 0;
      clken = 1'b1;
      while ((sent < 50 || q.size() > 0) && cyc < 2000) begin
         in_valid  = (sent < 50);
         randomize_inputs();
         in_tag    = 4'(sent % 16);
         out_ready = 1'($urandom_range(1));
         #1;
         n_checks++; if (in_ready !== m_ready()) begin n_fail++; $display("FAIL b2b_ready cyc=%0d: got %0b want %0b", cyc, in_ready, m_ready()); end
         n_checks++; if (out_valid !== m_out_valid()) begin n_fail++; $display("FAIL b2b_valid cyc=%0d: got %0b want %0b", cyc, out_valid, m_out_valid()); end
         n_checks++; if (inflight !== q.size() || inflight > 5'd21) begin n_fail++; $display("FAIL b2b_inflight cyc=%0d: got %0d want %0d (max 21)", cyc, inflight, q.size()); end
         if (m_out_valid()) begin
            n_checks++; if (out_data !== q[0].data) begin n_fail++; $display("FAIL b2b_data cyc=%0d: got %h want %h", cyc, out_data, q[0].data); end
            n_checks++; if (out_tag !== q[0].tag) begin n_fail++; $display("FAIL b2b_tag cyc=%0d: got %0d want %0d", cyc, out_tag, q[0].tag); end
            if (out_ready) got++;
         end
         tick(acc);
         if (acc) sent++;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n_checks++; if (cyc >= 2000) begin n_fail++; $display("FAIL b2b_timeout: got %0d cycles want < 2000", cyc); end
      n_checks++; if (got != 50) begin n_fail++; $display("FAIL b2b_count: got %0d results want 50", got); end
   endtask

   task automatic test_full();
      bit acc;
      int cyc = 0, tg = 0;
      clken = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         randomize_inputs();
         in_tag = 4'(tg);
         #1;
         n_checks++; if (in_ready !== m_ready()) begin n_fail++; $display("FAIL full_ready i=%0d: got %0b want %0b", i, in_ready, m_ready()); end
         n_checks++; if (inflight !== q.size()) begin n_fail++; $display("FAIL full_inflight i=%0d: got %0d want %0d", i, inflight, q.size()); end
         tick(acc);
         if (acc) tg++;
      end
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_stall_ready: got %0b want 0", in_ready); end
      n_checks++; if (inflight !== 5'd21) begin n_fail++; $display("FAIL full_stall_inflight: got %0d want 21", inflight); end
      in_valid = 1'b0; out_ready = 1'b1;
      while (q.size() > 0 && cyc < 100) begin
         #1;
         n_checks++; if (out_valid !== m_out_valid()) begin n_fail++; $display("FAIL full_drain_valid cyc=%0d: got %0b want %0b", cyc, out_valid, m_out_valid()); end
         if (m_out_valid()) begin
            n_checks++; if (out_data !== q[0].data || out_tag !== q[0].tag) begin n_fail++; $display("FAIL full_drain_data cyc=%0d: got %h/%0d want %h/%0d", cyc, out_data, out_tag, q[0].data, q[0].tag); end
         end
         tick(acc);
         cyc++;
      end
      n_checks++; if (cyc >= 100 || inflight !== 5'd0) begin n_fail++; $display("FAIL full_drain_end: got cyc=%0d inflight=%0d want drained", cyc, inflight); end
   endtask

   task automatic test_clken();
      bit acc;
      int cyc = 0;
      out_ready = 1'b1;
      while ((cyc < 40 || q.size() > 0) && cyc < 200) begin
         clken    = !(cyc >= 25 && cyc < 30);
         in_valid = (cyc < 40);
         randomize_inputs();
         in_tag = 4'(cyc);
         #1;
         if (!clken) begin
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ce_ready cyc=%0d: got %0b want 0", cyc, in_ready); end
         end
         n_checks++; if (inflight !== q.size()) begin n_fail++; $display("FAIL ce_inflight cyc=%0d: got %0d want %0d", cyc, inflight, q.size()); end
         n_checks++; if (out_valid !== m_out_valid()) begin n_fail++; $display("FAIL ce_valid cyc=%0d: got %0b want %0b", cyc, out_valid, m_out_valid()); end
         if (m_out_valid()) begin
            n_checks++; if (out_data !== q[0].data || out_tag !== q[0].tag) begin n_fail++; $display("FAIL ce_data cyc=%0d: got %h/%0d want %h/%0d", cyc, out_data, out_tag, q[0].data, q[0].tag); end
         end
         tick(acc);
         cyc++;
      end
      clken = 1'b1; in_valid = 1'b0;
      n_checks++; if (cyc >= 200) begin n_fail++; $display("FAIL ce_timeout: got %0d cycles want < 200", cyc); end
   endtask

   task automatic test_reset_mid();
      bit acc;
      clken = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         randomize_inputs();
         tick(acc);
      end
      n_checks++; if (inflight !== 5'd10) begin n_fail++; $display("FAIL rmid_pre_inflight: got %0d want 10", inflight); end
      rst = 1'b1;
      tick(acc);
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %0b want 0", out_valid); end
      n_checks++; if (inflight !== 5'd0) begin n_fail++; $display("FAIL rmid_inflight: got %0d want 0", inflight); end
      for (int i = 0; i < 30; i++) begin
         tick(acc);
         n_checks++; if (out_valid !== 1'b0 || inflight !== 5'd0) begin n_fail++; $display("FAIL rmid_stale i=%0d: got valid %0b inflight %0d want 0/0", i, out_valid, inflight); end
      end
   endtask

   initial begin
      test_reset();
      test_modes();
      test_wrap();
      test_back_to_back();
      test_full();
      test_clken();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fma_vec_pipe.md
FMA_VEC_PIPE -- requirements
Module: fma_vec_pipe

Interface
REQ-001 Parameter W, default 32, lane operand/result width in bits (>=2).
REQ-002 Parameter LANES, default 4, number of independent FMA lanes (>=1).
REQ-003 Parameter DELAY, default 21, pipeline depth in cycles from accept to result (>=1).
REQ-004 Parameter TAG_W, default 4, width of the sideband tag carried alongside each operation (>=1).
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 clken  input  1  global clock enable; when low, no state changes.
REQ-008 in_valid  input  1  operand bundle present.
REQ-009 in_ready  output  1  block accepts a bundle this cycle.
REQ-010 in_a, in_b, in_c  input  LANES*W each  packed lane operands; lane i at bits [i*W +: W].
REQ-011 in_mode  input  2  operation select, shared by all lanes of the bundle.
REQ-012 in_tag  input  TAG_W  sideband tag, returned unchanged with the result.
REQ-013 out_valid  output  1  result bundle present.
REQ-014 out_ready  input  1  downstream consumes the result this cycle.
REQ-015 out_data  output  LANES*W  packed lane results.
REQ-016 out_tag  output  TAG_W  tag of the bundle on out_data.
REQ-017 inflight  output  clog2(DELAY+1)  number of valid bundles held in the pipeline.

Function
REQ-018 Per lane, mode 00 -> a*b+c; 01 -> a*b-c; 10 -> c-a*b; 11 -> a*b (c ignored).
REQ-019 Arithmetic is two's-complement integer; product and sum are taken modulo 2^W (low W bits kept, no saturation, no overflow flag).
REQ-020 The pipeline is DELAY stages, each holding a valid bit, LANES*W result bits and TAG_W tag bits; the result is computed combinationally into stage 0.
REQ-021 advance = clken & (~out_valid | out_ready); in_ready = advance.
REQ-022 On a clock edge with advance=1, every stage shifts by one; stage 0 loads valid = in_valid and the computed result and tag.
REQ-023 On an edge with advance=0, all stages hold their contents; a bubble (valid=0) never blocks a shift.
REQ-024 A bundle is accepted on an edge where in_valid & in_ready; it is consumed on an edge where out_valid & out_ready & clken.
REQ-025 out_valid, out_data and out_tag are driven directly from the last stage, with no combinational path from in_* to out_*.
REQ-026 Latency: with no stalls, a bundle accepted on edge k appears with out_valid=1 after edge k+DELAY-1 and is consumed on edge k+DELAY when out_ready=1; each stall cycle adds one cycle.
REQ-027 Throughput is one bundle per cycle while out_ready=1 and clken=1.
REQ-028 inflight counts the set valid bits across all stages: +1 on accept, -1 on consume, unchanged when both or neither occur.
REQ-029 When clken=0, in_ready=0 and no accept or consume occurs, regardless of in_valid and out_ready.
REQ-030 Results on out_data while out_valid=0 are don't-care for checking, but they shall be deterministic.
REQ-031 Lanes are fully independent; a lane's result depends only on that lane's operands and the shared mode.

Reset
REQ-032 While rst=1 on a clock edge, irrespective of clken, all valid bits, data and tags clear to 0; after that edge out_valid=0, out_data=0, out_tag=0, inflight=0.
REQ-033 Reset asserted mid-operation discards all in-flight bundles with no output produced; in_valid is ignored on reset edges.
REQ-034 in_ready is combinational per REQ-021 and reads 1 after reset whenever clken=1.

Verification
REQ-035 W=32, LANES=4, DELAY=21, out_ready=1: one bundle, a=3, b=5, c=2, in all 4 lanes with modes 00/01/10/11 on successive bundles -> 17, 13, -13 (0xFFFFFFF3), 15 at consecutive cycles starting 21 cycles after accept.
REQ-036 Wrap: a=0x80000000, b=2, c=1, mode 00 -> out 0x00000001; a=0xFFFFFFFF, b=0xFFFFFFFF, c=0, mode 11 -> out 1.
REQ-037 Back-to-back stream of 50 bundles with tags 0..15 repeating, out_ready toggling randomly -> every result/tag appears exactly once, in order; inflight never exceeds 21; no bundle is lost or duplicated.
REQ-038 Pipeline full: out_ready=0 for 40 cycles while in_valid=1 -> in_ready drops once out_valid=1; inflight holds; release -> outputs resume with correct order.
REQ-039 clken=0 for 5 cycles mid-stream -> no state change, in_ready=0, inflight constant; stream resumes unchanged.
REQ-040 rst=1 for one cycle with inflight=10 -> next cycle out_valid=0, inflight=0, and no stale result ever appears afterward.
